btb_client: RTL

Frontend-side initiator for the BTB request/update interface. It accepts fetch PCs and issues one BTB lookup per accepted PC. It captures the BTB response one cycle later and presents it as a registered, back-pressurable prediction. It also buffers resolved-branch updates from the backend in a small FIFO and drains them to the BTB update port one per cycle.

---
 rtl/btb_client_pkg.sv | 21 ++
 rtl/btb_upd_fifo.sv | 55 +++++
 rtl/btb_client.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/btb_client_pkg.sv
// Shared types and widths for the BTB client: update payloads and registered predictions.
package btb_client_pkg;

    localparam int PC_W = 64;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic            is_br;
        logic            is_jal;
    } btb_upd_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            hit;
        logic [PC_W-1:0] target;
        logic            is_br;
        logic            is_jal;
    } btb_pred_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Resolved-branch update FIFO. The head is popped every cycle it is valid because the BTB update
// port has no backpressure.
module btb_upd_fifo
    import btb_client_pkg::*;
#(
    parameter int  UPD_DEPTH = 4,
    localparam int PTR_W     = $clog2(UPD_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  btb_upd_t         data_i,
    output logic             ready_o,
    output logic             valid_o,
    output btb_upd_t         data_o,
    output logic [CNT_W-1:0] count_o
);

    btb_upd_t         mem_q [UPD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    // No full-bypass: a push is refused when full even if the head pops this cycle.
    assign ready_o = (count_q != CNT_W'(UPD_DEPTH));
    assign valid_o = (count_q != '0);
    assign push    = push_i && ready_o;
    assign pop     = valid_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/btb_client.sv
// Frontend BTB initiator: two-stage lookup pipe plus update FIFO drain.
// Optional BTB_CLIENT_FWD_EN forwards same-PC updates into the in-flight lookup.
module btb_client
    import btb_client_pkg::*;
#(
    parameter int UPD_DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    input  logic [PC_W-1:0]            fetch_pc_i,
    output logic                       pred_valid_o,
    input  logic                       pred_ready_i,
    output logic [PC_W-1:0]            pred_pc_o,
    output logic                       pred_hit_o,
    output logic [PC_W-1:0]            pred_target_o,
    output logic                       pred_is_br_o,
    output logic                       pred_is_jal_o,
    output logic                       btb_req_valid_o,
    output logic [PC_W-1:0]            btb_req_pc_o,
    input  logic                       btb_req_target_valid_i,
    input  logic [PC_W-1:0]            btb_req_target_pc_i,
    input  logic                       btb_req_is_br_i,
    input  logic                       btb_req_is_jal_i,
    input  logic                       upd_in_valid_i,
    output logic                       upd_in_ready_o,
    input  logic [PC_W-1:0]            upd_in_pc_i,
    input  logic [PC_W-1:0]            upd_in_target_i,
    input  logic                       upd_in_is_br_i,
    input  logic                       upd_in_is_jal_i,
    output logic                       btb_update_valid_o,
    output logic [PC_W-1:0]            btb_update_pc_o,
    output logic [PC_W-1:0]            btb_update_target_o,
    output logic                       btb_update_is_br_o,
    output logic                       btb_update_is_jal_o,
    output logic [$clog2(UPD_DEPTH):0] upd_count_o
);

    logic            s1_v_q, s1_v_d;
    logic [PC_W-1:0] s1_pc_q, s1_pc_d;
    logic            pred_valid_q, pred_valid_d;
    btb_pred_t       pred_q, pred_d;
    logic            s2_free, s1_adv, req_fire;
    btb_upd_t        upd_in, upd_head;
    logic            upd_valid;

    assign s2_free         = !pred_valid_q || pred_ready_i;
    assign s1_adv          = s1_v_q && s2_free;
    assign fetch_ready_o   = !flush_i && (!s1_v_q || s1_adv);
    assign req_fire        = fetch_valid_i && fetch_ready_o;
    assign btb_req_valid_o = req_fire;
    assign btb_req_pc_o    = fetch_pc_i;

    assign upd_in = '{pc: upd_in_pc_i, target: upd_in_target_i,
                      is_br: upd_in_is_br_i, is_jal: upd_in_is_jal_i};

    btb_upd_fifo #(.UPD_DEPTH(UPD_DEPTH)) u_upd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (upd_in_valid_i),
        .data_i  (upd_in),
        .ready_o (upd_in_ready_o),
        .valid_o (upd_valid),
        .data_o  (upd_head),
        .count_o (upd_count_o)
    );

    assign btb_update_valid_o  = upd_valid;
    assign btb_update_pc_o     = upd_head.pc;
    assign btb_update_target_o = upd_head.target;
    assign btb_update_is_br_o  = upd_head.is_br;
    assign btb_update_is_jal_o = upd_head.is_jal;

`ifdef BTB_CLIENT_FWD_EN
    logic            fwd_v_q, fwd_v_d;
    logic [PC_W-1:0] fwd_target_q, fwd_target_d;
    logic            fwd_br_q, fwd_br_d;
    logic            fwd_jal_q, fwd_jal_d;
    logic            fwd_load;

    // The BTB response reflects pre-update state, so a same-PC update seen while the lookup is
    // being issued or parked in S1 must override it.
    always_comb begin
        fwd_v_d      = fwd_v_q;
        fwd_target_d = fwd_target_q;
        fwd_br_d     = fwd_br_q;
        fwd_jal_d    = fwd_jal_q;
        fwd_load     = 1'b0;
        if (req_fire) begin
            fwd_v_d  = upd_valid && (upd_head.pc == fetch_pc_i);
            fwd_load = fwd_v_d;
        end else if (s1_v_q && !s1_adv && upd_valid && (upd_head.pc == s1_pc_q)) begin
            fwd_v_d  = 1'b1;
            fwd_load = 1'b1;
        end
        if (fwd_load) begin
            fwd_target_d = upd_head.target;
            fwd_br_d     = upd_head.is_br;
            fwd_jal_d    = upd_head.is_jal;
        end
        if (flush_i) fwd_v_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fwd_v_q      <= 1'b0;
            fwd_target_q <= '0;
            fwd_br_q     <= 1'b0;
            fwd_jal_q    <= 1'b0;
        end else begin
            fwd_v_q      <= fwd_v_d;
            fwd_target_q <= fwd_target_d;
            fwd_br_q     <= fwd_br_d;
            fwd_jal_q    <= fwd_jal_d;
        end
    end
`endif

    always_comb begin
        s1_v_d       = s1_v_q;
        s1_pc_d      = s1_pc_q;
        pred_valid_d = pred_valid_q;
        pred_d       = pred_q;

        if (s1_adv) begin
            pred_valid_d  = 1'b1;
            pred_d.pc     = s1_pc_q;
            pred_d.hit    = btb_req_target_valid_i;
            pred_d.target = btb_req_target_pc_i;
            pred_d.is_br  = btb_req_is_br_i;
            pred_d.is_jal = btb_req_is_jal_i;
`ifdef BTB_CLIENT_FWD_EN
            if (fwd_v_q) begin
                pred_d.hit    = 1'b1;
                pred_d.target = fwd_target_q;
                pred_d.is_br  = fwd_br_q;
                pred_d.is_jal = fwd_jal_q;
            end
`endif
        end else if (pred_valid_q && pred_ready_i) begin
            pred_valid_d = 1'b0;
        end

        if (req_fire) begin
            s1_v_d  = 1'b1;
            s1_pc_d = fetch_pc_i;
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end

        if (flush_i) begin
            s1_v_d       = 1'b0;
            pred_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_v_q       <= 1'b0;
            s1_pc_q      <= '0;
            pred_valid_q <= 1'b0;
            pred_q       <= '0;
        end else begin
            s1_v_q       <= s1_v_d;
            s1_pc_q      <= s1_pc_d;
            pred_valid_q <= pred_valid_d;
            pred_q       <= pred_d;
        end
    end

    assign pred_valid_o  = pred_valid_q;
    assign pred_pc_o     = pred_q.pc;
    assign pred_hit_o    = pred_q.hit;
    assign pred_target_o = pred_q.target;
    assign pred_is_br_o  = pred_q.is_br;
    assign pred_is_jal_o = pred_q.is_jal;

endmodule
